key_filter_multi: RTL and testbench



---
 rtl/key_filter_multi.sv | 143 ++++++++++++++
 tb/tb_key_filter_multi.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/key_filter_multi.sv
// Multi-channel active-low key debouncer: press/release/long-press pulses plus a clean level per channel.
// Define KEY_REPEAT_EN to make key_long auto-repeat every REPEAT_CYC clocks while a key stays held.
module key_filter_multi #(
    parameter int unsigned KEY_NUM    = 4,
    parameter logic [19:0] CNT_MAX    = 20'd999_999,
    parameter logic [31:0] LONG_MAX   = 32'd49_999_999,
    parameter logic [31:0] REPEAT_CYC = 32'd9_999_999
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long,
    output logic [KEY_NUM-1:0] key_state
);

    localparam int unsigned DW = $clog2(32'(CNT_MAX) + 32'd1);
    localparam int unsigned HW = $clog2(33'(LONG_MAX) + 33'd1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(CNT_MAX - 20'd1);
    localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_MAX - 32'd1);
    localparam logic [HW-1:0] HCNT_MAX  = HW'(LONG_MAX);

    typedef enum logic [1:0] {IDLE, HELD, REL_FILT} state_t;

    if (KEY_NUM < 1 || KEY_NUM > 16 || CNT_MAX < 20'd2 ||
        LONG_MAX <= 32'(CNT_MAX) || REPEAT_CYC == 32'd0) begin : g_param_err
        $error("key_filter_multi: illegal parameter combination");
    end

    logic [KEY_NUM-1:0] sync1_q;
    logic [KEY_NUM-1:0] sync2_q;

    // Synchronisers park at 1 so a key held through reset still looks like a fresh press.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        state_t        state_q;
        logic [DW-1:0] dcnt_q;
        logic [HW-1:0] hcnt_q;
        logic          press_q;
        logic          release_q;
        logic          long_q;
        logic          level_q;
`ifdef KEY_REPEAT_EN
        localparam int unsigned RW = $clog2(33'(REPEAT_CYC) + 33'd1);
        localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_CYC - 32'd1);
        logic [RW-1:0] rcnt_q;
`endif

        // hcnt advances on every HELD clock (including the one that leaves for REL_FILT) and is
        // frozen otherwise, so a release glitch delays key_long by exactly its own length.
        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                state_q   <= IDLE;
                dcnt_q    <= '0;
                hcnt_q    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                level_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
                rcnt_q    <= '0;
`endif
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (sync2_q[i]) begin
                            dcnt_q <= '0;
                        end else if (dcnt_q == DCNT_LAST) begin
                            press_q <= 1'b1;
                            level_q <= 1'b1;
                            dcnt_q  <= '0;
                            hcnt_q  <= '0;
                            state_q <= HELD;
                        end else begin
                            dcnt_q <= dcnt_q + DW'(1);
                        end
                    end
                    HELD: begin
                        if (hcnt_q != HCNT_MAX) begin
                            hcnt_q <= hcnt_q + HW'(1);
                        end
                        if (hcnt_q == HCNT_LAST) begin
                            long_q <= 1'b1;
`ifdef KEY_REPEAT_EN
                            rcnt_q <= '0;
                        end else if (hcnt_q == HCNT_MAX) begin
                            if (rcnt_q == RCNT_LAST) begin
                                long_q <= 1'b1;
                                rcnt_q <= '0;
                            end else begin
                                rcnt_q <= rcnt_q + RW'(1);
                            end
`endif
                        end
                        if (sync2_q[i]) begin
                            dcnt_q  <= DW'(1);
                            state_q <= REL_FILT;
                        end
                    end
                    REL_FILT: begin
                        if (!sync2_q[i]) begin
                            dcnt_q  <= '0;
                            state_q <= HELD;
                        end else if (dcnt_q == DCNT_LAST) begin
                            release_q <= 1'b1;
                            level_q   <= 1'b0;
                            dcnt_q    <= '0;
                            hcnt_q    <= '0;
`ifdef KEY_REPEAT_EN
                            rcnt_q    <= '0;
`endif
                            state_q   <= IDLE;
                        end else begin
                            dcnt_q <= dcnt_q + DW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end

        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_long[i]    = long_q;
        assign key_state[i]   = level_q;
    end

endmodule

// File: tb/tb_key_filter_multi.sv
// Self-checking bench for key_filter_multi: expected events are queued with their due cycle
// when keys are driven and matched against every pulse the DUT produces.
module tb_key_filter_multi;

    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_LONG    = 2;
    localparam int DEB_LAT    = 26;
    localparam int LONG_LAT   = 200;

    typedef struct {
        int kind;
        int ch;
        int at;
    } ev_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic [3:0] key_in  = 4'hF;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;
    logic [3:0] key_state;

    int   cyc        = 0;
    int   compared   = 0;
    int   mismatched = 0;
    ev_t  sb[$];

    key_filter_multi #(
        .KEY_NUM   (4),
        .CNT_MAX   (20'd24),
        .LONG_MAX  (32'd200),
        .REPEAT_CYC(32'd50)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_in     (key_in),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long),
        .key_state  (key_state)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Every observed pulse must match the oldest queued event of the same kind and channel,
    // and arrive exactly on its due cycle; an unexpected pulse is compared against "none" (-1).
    logic  bitv;
    int    idx;
    int    expCyc;
    string kindName;
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            for (int ch = 0; ch < 4; ch++) begin
                for (int k = 0; k < 3; k++) begin
                    bitv = (k == EV_PRESS) ? key_press[ch] :
                           (k == EV_RELEASE) ? key_release[ch] : key_long[ch];
                    if (bitv !== 1'b0) begin
                        idx = -1;
                        foreach (sb[j]) begin
                            if (idx < 0 && sb[j].kind == k && sb[j].ch == ch) idx = j;
                        end
                        expCyc   = (idx < 0) ? -1 : sb[idx].at;
                        kindName = (k == EV_PRESS) ? "press" : (k == EV_RELEASE) ? "release" : "long";
                        compared++;
                        assert (cyc === expCyc) else begin
                            mismatched++;
                            $error("[TB] FAIL %s ch%0d: pulse at cycle %0d, expected cycle %0d (-1 = none)",
                                   kindName, ch, cyc, expCyc);
                        end
                        if (idx >= 0) sb.delete(idx);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic pushExpected(input int kind, input int ch, input int at);
        ev_t e;
        e.kind = kind;
        e.ch   = ch;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] keys);
        key_in = keys;
    endtask

    initial begin
        #1 sys_rst = 1'b1;
        step(3);
        checkOutput("resetOutputs", {key_press, key_release, key_long, key_state}, 32'h0);
        sys_rst = 1'b0;
        step(5);

        $display("[TB] clean press on ch0");
        applyStimulus(4'b1110);
        pushExpected(EV_PRESS, 0, cyc + DEB_LAT);
        step(30);
        checkOutput("cleanHeldState", key_state, 4'b0001);
        step(30);
        applyStimulus(4'b1111);
        pushExpected(EV_RELEASE, 0, cyc + DEB_LAT);
        step(40);
        checkOutput("cleanReleasedState", key_state, 4'b0000);
        checkOutput("cleanDrained", sb.size(), 0);

        $display("[TB] bouncing press on ch1");
        for (int i = 0; i < 30; i++) begin
            applyStimulus({2'b11, (i % 8 == 7 || i == 29) ? 1'b1 : 1'($urandom % 2), 1'b1});
            step(1);
        end
        applyStimulus(4'b1101);
        pushExpected(EV_PRESS, 1, cyc + DEB_LAT);
        step(100);
        checkOutput("bounceHeldState", key_state, 4'b0010);
        applyStimulus(4'b1111);
        pushExpected(EV_RELEASE, 1, cyc + DEB_LAT);
        step(40);
        applyStimulus(4'b1101);
        step(20);
        applyStimulus(4'b1111);
        step(40);
        checkOutput("glitchNoState", key_state, 4'b0000);
        checkOutput("bounceDrained", sb.size(), 0);

        $display("[TB] long press on ch2");
        applyStimulus(4'b1011);
        pushExpected(EV_PRESS, 2, cyc + DEB_LAT);
        pushExpected(EV_LONG, 2, cyc + DEB_LAT + LONG_LAT);
        step(400);
        applyStimulus(4'b1111);
        pushExpected(EV_RELEASE, 2, cyc + DEB_LAT);
        step(40);
        checkOutput("longDrained", sb.size(), 0);

        $display("[TB] release glitch on ch3");
        applyStimulus(4'b0111);
        pushExpected(EV_PRESS, 3, cyc + DEB_LAT);
        pushExpected(EV_LONG, 3, cyc + DEB_LAT + LONG_LAT + 10);
        step(100);
        applyStimulus(4'b1111);
        step(10);
        checkOutput("glitchStillHeld", key_state, 4'b1000);
        applyStimulus(4'b0111);
        step(190);
        applyStimulus(4'b1111);
        pushExpected(EV_RELEASE, 3, cyc + DEB_LAT);
        step(40);
        checkOutput("glitchDrained", sb.size(), 0);

        $display("[TB] simultaneous press on all channels");
        applyStimulus(4'b0000);
        for (int ch = 0; ch < 4; ch++) pushExpected(EV_PRESS, ch, cyc + DEB_LAT);
        step(DEB_LAT);
        checkOutput("simulPress", key_press, 4'hF);
        step(34);
        applyStimulus(4'b1111);
        for (int ch = 0; ch < 4; ch++) pushExpected(EV_RELEASE, ch, cyc + DEB_LAT);
        step(DEB_LAT);
        checkOutput("simulRelease", key_release, 4'hF);
        step(14);
        checkOutput("simulDrained", sb.size(), 0);

        $display("[TB] reset while ch0 is held");
        applyStimulus(4'b1110);
        pushExpected(EV_PRESS, 0, cyc + DEB_LAT);
        step(40);
        checkOutput("preResetState", key_state, 4'b0001);
        sys_rst = 1'b1;
        #1;
        checkOutput("midResetOutputs", {key_press, key_release, key_long, key_state}, 32'h0);
        step(3);
        sys_rst = 1'b0;
        pushExpected(EV_PRESS, 0, cyc + DEB_LAT);
        step(30);
        checkOutput("postResetState", key_state, 4'b0001);
        applyStimulus(4'b1111);
        pushExpected(EV_RELEASE, 0, cyc + DEB_LAT);
        step(40);
        checkOutput("finalDrained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
